led_blink_src: RTL and testbench
================================

# led_blink_src

Source side of the LED blink interface: generates the free-running `second_tick` square wave and the single-cycle `trig` requests that LED blink consumers act on. Event pulses from system logic are counted in a saturating pending counter. Each pending event is issued as exactly one `trig`, aligned to a `second_tick` falling edge and paced so consecutive blinks stay visually distinct. Sits in the top-level status block; one instance can drive several LED blink consumers.

## Interface
- `TICK_HALF`, 25_000_000: clk cycles per `second_tick` half-period; full period = 2*TICK_HALF; legal range ≥ 2.
- `CNT_W`, 4: width of the pending-event counter; saturates at 2^CNT_W-1.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `event_in`  in  1  one-cycle event request; each high cycle counts as one event.
- `event_clr`  in  1  one-cycle clear of `pend_cnt` and `ovf`.
- `second_tick`  out  1  50% duty square wave, registered.
- `trig`  out  1  one-cycle blink request, registered.
- `pend_cnt`  out  CNT_W  events accepted but not yet issued.
- `ovf`  out  1  sticky; an event was dropped at saturation.
- `busy`  out  1  high when the FSM is not IDLE.

## Operation
- Divider `div` counts 0..TICK_HALF-1 and wraps to 0. On the wrap cycle, `second_tick` toggles.
- `tick_fall` = wrap cycle with `second_tick`==1. It is internal and combinational.
- FSM states and transitions:
  - IDLE: on `tick_fall` with `pend_cnt`>0, assert `trig` for one cycle, decrement `pend_cnt`, go to BLINK.
  - BLINK: the consumer lights the LED on the next rising edge and clears it on the next falling edge. On the next `tick_fall`, go to GAP.
  - GAP: enforces one full dark period. On the next `tick_fall`, go to IDLE. In that same cycle, IDLE is not re-evaluated, so the next trig comes at the following `tick_fall`.
- Resulting blink pitch: one `trig` per 3 tick periods when events are back-to-back. The trig-to-trig interval is 6*TICK_HALF cycles.
- Pending counter, same-cycle events:
  - `event_in` alone: +1, saturating.
  - Trig issue alone: -1.
  - Both: unchanged.
  - `event_in` while at 2^CNT_W-1 with no decrement that cycle: count holds and `ovf` is set to 1.
- `event_clr` takes priority over `event_in` and the decrement in the same cycle. It sets `pend_cnt` to 0 and `ovf` to 0. The FSM and divider are unaffected; a blink already in BLINK or GAP completes normally.
- A `trig` is never issued with `pend_cnt`==0, and never outside a `tick_fall` cycle.
- `busy` is 1 in BLINK and GAP.

## Timing
- Reset values (first clock edge with `rst`=1): `div`=0, `second_tick`=0, `trig`=0, `pend_cnt`=0, `ovf`=0, FSM=IDLE, `busy`=0.
- `rst` asserted mid-operation forces all of the above in one cycle, discarding pending events and any in-flight blink.
- After `rst` deasserts (cycle 0 = first non-reset edge):
  - `second_tick` rises on the edge ending cycle TICK_HALF-1.
  - It falls TICK_HALF cycles later, and so on.
- `trig` is registered: it goes high on the same edge where `second_tick` goes 1→0 and is high for exactly one cycle.
- `event_in` latency to `pend_cnt`: 1 cycle.
- Event-to-trig latency from IDLE is at most 2*TICK_HALF+1 cycles. It is longer if earlier events are queued or the FSM is in BLINK or GAP.
- `pend_cnt` decrement and `busy` rise are visible in the same cycle as `trig`.

## Test plan
- **Reset and tick free-run** (TICK_HALF=4). Release `rst`; expect:
  - `second_tick` 0 for cycles 0-3, 1 for cycles 4-7, 0 for cycles 8-11;
  - `trig`=0 throughout, `pend_cnt`=0, `busy`=0.
- **Single event** (TICK_HALF=4). Pulse `event_in` at cycle 1; expect:
  - `pend_cnt`=1 at cycle 2;
  - `trig`=1 only at cycle 8, with `second_tick`=0 and `pend_cnt`=0;
  - `busy`=1 over cycles 8-23, 0 from cycle 24.
- **Back-to-back events** (TICK_HALF=4). Pulse `event_in` at cycles 1, 2, 3; expect:
  - `pend_cnt`=3 at cycle 4;
  - `trig` at cycles 8, 32, 56 (24 cycles apart);
  - `pend_cnt` 2 / 1 / 0 after each trig.
- **Saturation and overflow** (CNT_W=2). Pulse `event_in` 5 times while idle and before the first `tick_fall`; expect `pend_cnt`=3 and `ovf`=1. Then pulse `event_clr`; expect `pend_cnt`=0 and `ovf`=0 next cycle, and no trig follows.
- **Simultaneous events:**
  - `event_in` high in the `trig` cycle: `pend_cnt` unchanged.
  - `event_clr` and `event_in` in the same cycle: `pend_cnt`=0, `ovf`=0.
  - `event_clr` while in BLINK: `busy` stays high until GAP exits normally.
- **Mid-operation reset.** Assert `rst` for 1 cycle while in BLINK with `pend_cnt`=2; expect all outputs at reset values next cycle. `second_tick` then restarts its 0-for-TICK_HALF sequence and no `trig` is issued.

Source files
------------

// File: rtl/led_blink_src_if.sv
// Signal bundle between system logic and the LED blink source.
// The master side raises events; the slave side (led_blink_src) drives the tick, the trigger and the status.
interface led_blink_src_if #(
    parameter int CNT_W = 4
);
    logic             event_in;
    logic             event_clr;
    logic             second_tick;
    logic             trig;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;
    logic             busy;

    modport master (
        output event_in,
        output event_clr,
        input  second_tick,
        input  trig,
        input  pend_cnt,
        input  ovf,
        input  busy
    );

    modport slave (
        input  event_in,
        input  event_clr,
        output second_tick,
        output trig,
        output pend_cnt,
        output ovf,
        output busy
    );
endinterface

// File: rtl/led_blink_src.sv
// LED blink source: free-running second_tick square wave plus paced one-cycle trig pulses.
// Each queued event yields one trig on a tick falling edge, followed by a blink period and a dark period.
module led_blink_src #(
    parameter int TICK_HALF = 25_000_000,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    led_blink_src_if.slave        bus
);

    localparam int                DIV_W    = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             trig_q, trig_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             wrap;
    logic             tickFall;

    assign wrap     = (div_q == DIV_LAST);
    assign tickFall = wrap && tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            trig_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            trig_q  <= trig_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        div_d  = wrap ? '0 : div_q + 1'b1;
        tick_d = wrap ? ~tick_q : tick_q;
    end

    // GAP returns to IDLE without evaluating IDLE that cycle, which keeps blinks three periods apart.
    always_comb begin
        state_d = state_q;
        trig_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tickFall && (pend_q != '0)) begin
                    trig_d  = 1'b1;
                    state_d = BLINK;
                end
            end
            BLINK: begin
                if (tickFall) state_d = GAP;
            end
            GAP: begin
                if (tickFall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over everything; an event in the issue cycle cancels the decrement.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (bus.event_clr) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (bus.event_in && !trig_d) begin
            if (pend_q == CNT_MAX) ovf_d = 1'b1;
            else                   pend_d = pend_q + 1'b1;
        end else if (!bus.event_in && trig_d) begin
            pend_d = pend_q - 1'b1;
        end
    end

    assign bus.second_tick = tick_q;
    assign bus.trig        = trig_q;
    assign bus.pend_cnt    = pend_q;
    assign bus.ovf         = ovf_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_led_blink_src.sv
// Directed testbench for led_blink_src with hand-computed cycle expectations.
// Cycle 0 is the first cycle after the reset edge; outputs are sampled 1 ns after each rising edge.
module tb_led_blink_src;

    localparam int TICK_HALF = 4;
    localparam int CNT_W     = 2;

    logic clk;
    logic rst;
    int   cyc;
    int   passCount;
    int   checkCount;

    led_blink_src_if #(.CNT_W(CNT_W)) bus ();

    led_blink_src #(
        .TICK_HALF (TICK_HALF),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive one cycle of event/clear, then return both to idle.
    task automatic applyStimulus(input logic ev, input logic clr);
        bus.event_in  = ev;
        bus.event_clr = clr;
        stepCycle();
        bus.event_in  = 1'b0;
        bus.event_clr = 1'b0;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.event_in  = 1'b0;
        bus.event_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " tick"}, int'(bus.second_tick), 0);
        checkOutput({tag, " trig"}, int'(bus.trig), 0);
        checkOutput({tag, " pend"}, int'(bus.pend_cnt), 0);
        checkOutput({tag, " ovf"},  int'(bus.ovf), 0);
        checkOutput({tag, " busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        cyc        = 0;
        rst        = 1'b1;
        bus.event_in  = 1'b0;
        bus.event_clr = 1'b0;

        // Reset and tick free-run
        doReset();
        checkResetState("rst");
        while (cyc <= 11) begin
            checkOutput("freerun tick", int'(bus.second_tick), (cyc >= 4 && cyc <= 7) ? 1 : 0);
            checkOutput("freerun trig", int'(bus.trig), 0);
            checkOutput("freerun busy", int'(bus.busy), 0);
            stepCycle();
        end

        // Single event
        doReset();
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("single pend", int'(bus.pend_cnt), 1);
        while (cyc <= 25) begin
            checkOutput("single trig", int'(bus.trig), (cyc == 8) ? 1 : 0);
            checkOutput("single busy", int'(bus.busy), (cyc >= 8 && cyc <= 23) ? 1 : 0);
            if (cyc == 8) begin
                checkOutput("single trig tick", int'(bus.second_tick), 0);
                checkOutput("single trig pend", int'(bus.pend_cnt), 0);
            end
            stepCycle();
        end

        // Back-to-back events
        doReset();
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("b2b pend", int'(bus.pend_cnt), 3);
        while (cyc <= 60) begin
            checkOutput("b2b trig", int'(bus.trig), (cyc == 8 || cyc == 32 || cyc == 56) ? 1 : 0);
            if (cyc == 8)  checkOutput("b2b pend after 1st", int'(bus.pend_cnt), 2);
            if (cyc == 32) checkOutput("b2b pend after 2nd", int'(bus.pend_cnt), 1);
            if (cyc == 56) checkOutput("b2b pend after 3rd", int'(bus.pend_cnt), 0);
            stepCycle();
        end

        // Saturation and overflow, then clear
        doReset();
        stepCycle();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("sat pend", int'(bus.pend_cnt), 3);
        checkOutput("sat ovf", int'(bus.ovf), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("clr pend", int'(bus.pend_cnt), 0);
        checkOutput("clr ovf", int'(bus.ovf), 0);
        while (cyc <= 40) begin
            checkOutput("clr no trig", int'(bus.trig), 0);
            stepCycle();
        end

        // Simultaneous events: event in issue cycle, then clear+event during BLINK
        doReset();
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        while (cyc < 7) stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("simul trig", int'(bus.trig), 1);
        checkOutput("simul pend held", int'(bus.pend_cnt), 1);
        stepCycle();
        applyStimulus(1'b1, 1'b1);
        checkOutput("clr+ev pend", int'(bus.pend_cnt), 0);
        checkOutput("clr+ev ovf", int'(bus.ovf), 0);
        while (cyc <= 40) begin
            checkOutput("clr blink busy", int'(bus.busy), (cyc <= 23) ? 1 : 0);
            checkOutput("clr blink trig", int'(bus.trig), 0);
            stepCycle();
        end

        // Mid-operation reset while in BLINK with two events pending
        doReset();
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        while (cyc < 10) stepCycle();
        checkOutput("pre-rst busy", int'(bus.busy), 1);
        checkOutput("pre-rst pend", int'(bus.pend_cnt), 2);
        doReset();
        checkResetState("midrst");
        while (cyc <= 30) begin
            checkOutput("midrst tick", int'(bus.second_tick), ((cyc / 4) % 2 == 1) ? 1 : 0);
            checkOutput("midrst trig", int'(bus.trig), 0);
            stepCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
